// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch squashes, data-memory
// waits with timeout, and the HALT drain/freeze sequence for the 5-stage core.
module pipeline_ctrl #(
   parameter int TIMEOUT      = 255,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       ifid_rs,
   input  logic [3:0]       ifid_rt,
   input  logic             ifid_usesrt,
   input  logic             ifid_halt,
   input  logic             idex_memread,
   input  logic [3:0]       idex_rd,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             pipe_en,
   output logic             halted,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_DRAIN  = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   localparam logic [1:0] DRAIN_INIT = 2'(DRAIN_CYCLES - 1);
   localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic [1:0]       drain_cnt_q, drain_cnt_d;
   logic             mem_err_q, mem_err_d;
   logic             halted_q, halted_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic             memwait_s;
   logic             loaduse_s;
   logic             stall_inc_s;

   assign memwait_s = mem_req & ~mem_ready;
   assign loaduse_s = idex_memread & (idex_rd != 4'd0) &
                      ((idex_rd == ifid_rs) | (ifid_usesrt & (idex_rd == ifid_rt)));

   // Next-state, counters and same-cycle control enables
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = 8'd0;
      drain_cnt_d   = drain_cnt_q;
      mem_err_d     = mem_err_q;
      stall_count_d = stall_count_q;
      stall_inc_s   = 1'b0;
      pc_write      = 1'b0;
      ifid_write    = 1'b0;
      ifid_flush    = 1'b0;
      idex_flush    = 1'b0;
      pipe_en       = 1'b0;

      case (state_q)
         S_RUN: begin
            if (memwait_s) begin
               stall_inc_s = 1'b1;
            end else if (branch_taken) begin
               pc_write   = 1'b1;
               ifid_write = 1'b1;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               pipe_en    = 1'b1;
            end else if (loaduse_s) begin
               idex_flush  = 1'b1;
               pipe_en     = 1'b1;
               stall_inc_s = 1'b1;
            end else if (ifid_halt) begin
               idex_flush  = 1'b1;
               pipe_en     = 1'b1;
               state_d     = S_DRAIN;
               drain_cnt_d = DRAIN_INIT;
            end else begin
               pc_write   = 1'b1;
               ifid_write = 1'b1;
               pipe_en    = 1'b1;
            end
         end
         S_DRAIN: begin
            // Only bubbles are in flight, so branch_taken has nothing to squash
            if (memwait_s) begin
               stall_inc_s = 1'b1;
            end else if (drain_cnt_q == 2'd0) begin
               idex_flush = 1'b1;
               pipe_en    = 1'b1;
               state_d    = S_HALTED;
            end else begin
               idex_flush  = 1'b1;
               pipe_en     = 1'b1;
               drain_cnt_d = drain_cnt_q - 2'd1;
            end
         end
         S_HALTED: begin
            state_d = S_HALTED;
         end
         default: begin
            state_d = S_RUN;
         end
      endcase

      if (memwait_s && (state_q != S_HALTED)) begin
         wait_cnt_d = wait_cnt_q + 8'd1;
         if (wait_cnt_q == WAIT_LAST) begin
            mem_err_d = 1'b1;
            state_d   = S_HALTED;
         end else begin
            mem_err_d = mem_err_q;
         end
      end else begin
         wait_cnt_d = 8'd0;
      end

      if (stall_inc_s && (stall_count_q != CNT_MAX)) begin
         stall_count_d = stall_count_q + CNT_ONE;
      end else begin
         stall_count_d = stall_count_q;
      end

      halted_d = (state_d == S_HALTED);

      // Reset holds the front end and squashes whatever sits in IF/ID and ID/EX
      if (rst) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         pipe_en    = 1'b0;
      end else begin
         pipe_en = pipe_en;
      end
   end

   // State and counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_RUN;
         wait_cnt_q    <= 8'd0;
         drain_cnt_q   <= 2'd0;
         mem_err_q     <= 1'b0;
         halted_q      <= 1'b0;
         stall_count_q <= {CNT_W{1'b0}};
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         drain_cnt_q   <= drain_cnt_d;
         mem_err_q     <= mem_err_d;
         halted_q      <= halted_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign halted      = halted_q;
   assign mem_err     = mem_err_q;
   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (TIMEOUT=8, DRAIN_CYCLES=3).
module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  ifid_rs, ifid_rt, idex_rd;
   logic        ifid_usesrt, ifid_halt, idex_memread, branch_taken, mem_req, mem_ready;
   logic        pc_write, ifid_write, ifid_flush, idex_flush, pipe_en, halted, mem_err;
   logic [15:0] stall_count;
   logic [4:0]  ctrl;
   int          checks = 0;
   int          errors = 0;

   // ctrl = {pc_write, ifid_write, ifid_flush, idex_flush, pipe_en}
   localparam logic [4:0] C_RUN    = 5'b11001;
   localparam logic [4:0] C_BUBBLE = 5'b00011;
   localparam logic [4:0] C_FREEZE = 5'b00000;
   localparam logic [4:0] C_BRANCH = 5'b11111;
   localparam logic [4:0] C_RESET  = 5'b00110;

   assign ctrl = {pc_write, ifid_write, ifid_flush, idex_flush, pipe_en};

   always #5 clk = ~clk;

   pipeline_ctrl #(.TIMEOUT(8), .DRAIN_CYCLES(3), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_usesrt(ifid_usesrt), .ifid_halt(ifid_halt),
      .idex_memread(idex_memread), .idex_rd(idex_rd), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .pipe_en(pipe_en), .halted(halted), .mem_err(mem_err),
      .stall_count(stall_count)
   );

   task automatic idle();
      ifid_rs = 4'd0; ifid_rt = 4'd0; ifid_usesrt = 1'b0; ifid_halt = 1'b0;
      idex_memread = 1'b0; idex_rd = 4'd0; branch_taken = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      step();
      step();
      @(negedge clk);
      checks++; if (ctrl !== C_RESET) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, C_RESET); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
      checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_mem_err: got %b expected 0", mem_err); end
      checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_stall_count: got %0d expected 0", stall_count); end
      step();
      rst = 1'b0;
      @(negedge clk);
      checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL reset_release_ctrl: got %b expected %b", ctrl, C_RUN); end
      step();
   endtask

   task automatic test_load_use();
      idex_memread = 1'b1; idex_rd = 4'd5; ifid_rs = 4'd5;
      @(negedge clk);
      checks++; if (ctrl !== C_BUBBLE) begin errors++; $display("FAIL loaduse_rs_ctrl: got %b expected %b", ctrl, C_BUBBLE); end
      step();
      idle();
      @(negedge clk);
      checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL loaduse_after_ctrl: got %b expected %b", ctrl, C_RUN); end
      checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL loaduse_stall_count: got %0d expected 1", stall_count); end
      step();
      idex_memread = 1'b1; idex_rd = 4'd0; ifid_rs = 4'd0;
      @(negedge clk);
      checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL loaduse_r0_ctrl: got %b expected %b", ctrl, C_RUN); end
      step();
      idex_rd = 4'd7; ifid_rs = 4'd3; ifid_rt = 4'd7; ifid_usesrt = 1'b0;
      @(negedge clk);
      checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL loaduse_rt_unused_ctrl: got %b expected %b", ctrl, C_RUN); end
      step();
      ifid_usesrt = 1'b1;
      @(negedge clk);
      checks++; if (ctrl !== C_BUBBLE) begin errors++; $display("FAIL loaduse_rt_ctrl: got %b expected %b", ctrl, C_BUBBLE); end
      step();
      idle();
      @(negedge clk);
      checks++; if (stall_count !== 16'd2) begin errors++; $display("FAIL loaduse_rt_stall_count: got %0d expected 2", stall_count); end
   endtask

   task automatic test_branch_priority();
      branch_taken = 1'b1; idex_memread = 1'b1; idex_rd = 4'd5; ifid_rs = 4'd5; ifid_halt = 1'b1;
      @(negedge clk);
      checks++; if (ctrl !== C_BRANCH) begin errors++; $display("FAIL branch_ctrl: got %b expected %b", ctrl, C_BRANCH); end
      step();
      idle();
      @(negedge clk);
      checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL branch_stays_run: got %b expected %b", ctrl, C_RUN); end
      checks++; if (stall_count !== 16'd2) begin errors++; $display("FAIL branch_stall_count: got %0d expected 2", stall_count); end
      step();
   endtask

   task automatic test_mem_wait();
      mem_req = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (ctrl !== C_FREEZE) begin errors++; $display("FAIL memwait_ctrl[%0d]: got %b expected %b", i, ctrl, C_FREEZE); end
         step();
      end
      mem_ready = 1'b1;
      @(negedge clk);
      checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL memwait_ready_ctrl: got %b expected %b", ctrl, C_RUN); end
      step();
      idle();
      @(negedge clk);
      checks++; if (stall_count !== 16'd6) begin errors++; $display("FAIL memwait_stall_count: got %0d expected 6", stall_count); end
      checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL memwait_mem_err: got %b expected 0", mem_err); end
      step();
   endtask

   task automatic test_halt_drain();
      logic [4:0] exp_seq [5];
      exp_seq[0] = C_BUBBLE; exp_seq[1] = C_FREEZE; exp_seq[2] = C_FREEZE;
      exp_seq[3] = C_BUBBLE; exp_seq[4] = C_BUBBLE;
      ifid_halt = 1'b1;
      @(negedge clk);
      checks++; if (ctrl !== C_BUBBLE) begin errors++; $display("FAIL halt_cycle_ctrl: got %b expected %b", ctrl, C_BUBBLE); end
      step();
      for (int i = 0; i < 5; i++) begin
         idle();
         mem_req      = (i == 1 || i == 2);
         branch_taken = (i == 3);
         @(negedge clk);
         checks++; if (ctrl !== exp_seq[i]) begin errors++; $display("FAIL drain_ctrl[%0d]: got %b expected %b", i, ctrl, exp_seq[i]); end
         checks++; if (halted !== 1'b0) begin errors++; $display("FAIL drain_halted[%0d]: got %b expected 0", i, halted); end
         step();
      end
      idle();
      @(negedge clk);
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_halted: got %b expected 1", halted); end
      checks++; if (ctrl !== C_FREEZE) begin errors++; $display("FAIL halt_frozen_ctrl: got %b expected %b", ctrl, C_FREEZE); end
      checks++; if (stall_count !== 16'd8) begin errors++; $display("FAIL halt_stall_count: got %0d expected 8", stall_count); end
      step();
   endtask

   task automatic test_reset_from_halted();
      rst = 1'b1;
      step();
      @(negedge clk);
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rsthalt_halted: got %b expected 0", halted); end
      checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL rsthalt_stall_count: got %0d expected 0", stall_count); end
      step();
      rst = 1'b0;
      @(negedge clk);
      checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL rsthalt_run_ctrl: got %b expected %b", ctrl, C_RUN); end
      step();
   endtask

   task automatic test_timeout();
      mem_req = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++; if ({mem_err, ctrl} !== {1'b0, C_FREEZE}) begin errors++; $display("FAIL timeout_wait[%0d]: got err=%b ctrl=%b expected err=0 ctrl=%b", i, mem_err, ctrl, C_FREEZE); end
         step();
      end
      @(negedge clk);
      checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL timeout_mem_err: got %b expected 1", mem_err); end
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL timeout_halted: got %b expected 1", halted); end
      checks++; if (stall_count !== 16'd8) begin errors++; $display("FAIL timeout_stall_count: got %0d expected 8", stall_count); end
      step();
      idle();
      @(negedge clk);
      checks++; if (ctrl !== C_FREEZE) begin errors++; $display("FAIL timeout_frozen_ctrl: got %b expected %b", ctrl, C_FREEZE); end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL timeout_rst_mem_err: got %b expected 0", mem_err); end
      checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL timeout_rst_ctrl: got %b expected %b", ctrl, C_RUN); end
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_load_use();
      test_branch_priority();
      test_mem_wait();
      test_halt_drain();
      test_reset_from_halted();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
